// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan logic: digit count, blank levels,
// the active-high hex glyph table and the per-slot state encoding.
package seg7_pkg;

  localparam int DIGITS = 8;

  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [6:0] CA_OFF = 7'h7F;

  // Glyphs as {g,f,e,d,c,b,a}, active-high; the pins invert them.
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

endpackage

// File: rtl/hex7_decode.sv
// Combinational nibble-to-glyph decoder; output is active-high {g,f,e,d,c,b,a}.
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit common-anode scanner with per-slot blanking guard and frame snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,  // cycles per digit slot, >= 4
  parameter int BLANK_CYCLES = 1000     // guard at slot start, 1 .. SCAN_DIV-1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [32:0] SEG,
  output logic [7:0]  AN,
  output logic [6:0]  CA
);

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYCLES);
  localparam logic [2:0]     DIG_LAST  = 3'(DIGITS - 1);

  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    dig_q,   dig_d;
  logic [32:0]   snap_q,  snap_d;
  slot_state_e   state_q, state_d;
  logic [7:0]    an_q,    an_d;
  logic [6:0]    ca_q,    ca_d;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          dig_show;

`ifdef SEG7_SCAN_LZB_EN
  logic [2:0] lead_q, lead_d;

  // Index of the highest nonzero nibble; digit 0 counts as leading when all are zero.
  function automatic logic [2:0] lead_of(input logic [31:0] v);
    lead_of = 3'd0;
    for (int d = 1; d < DIGITS; d++) begin
      if (v[4*d +: 4] != 4'h0) lead_of = 3'(d);
    end
  endfunction
`endif

  hex7_decode u_hex7 (
    .nib_i (nib),
    .seg_o (glyph)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (dig_q == DIG_LAST);

    cnt_d  = slot_end  ? '0 : cnt_q + CW'(1);
    dig_d  = slot_end  ? dig_q + 3'd1 : dig_q;
    snap_d = frame_end ? SEG : snap_q;

    state_d = (cnt_d < BLANK_LIM) ? ST_BLANK : ST_DRIVE;

`ifdef SEG7_SCAN_LZB_EN
    lead_d   = frame_end ? lead_of(SEG[31:0]) : lead_q;
    dig_show = (dig_d <= lead_d);
`else
    dig_show = 1'b1;
`endif

    // Outputs come from next-state values so the pins move on the same edge as the counters.
    nib  = snap_d[{dig_d, 2'b00} +: 4];
    an_d = AN_OFF;
    ca_d = CA_OFF;
    if (state_d == ST_DRIVE && snap_d[32] && dig_show) begin
      an_d = ~(8'b1 << dig_d);
      ca_d = ~glyph;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the snapshot is reset like any other register so the first frame after reset is guaranteed blank.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      snap_q  <= '0;
      state_q <= ST_BLANK;
      an_q    <= AN_OFF;
      ca_q    <= CA_OFF;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      snap_q  <= snap_d;
      state_q <= state_d;
      an_q    <= an_d;
      ca_q    <= ca_d;
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) lead_q <= 3'd0;
    else       lead_q <= lead_d;
  end
`endif

  assign AN = an_q;
  assign CA = ca_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_DIV=8, BLANK_CYCLES=2; expected pins are
// derived from cycle position and the frame value the bench expects on display.
module tb_seg7_scan;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 8 * SCAN_DIV;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [32:0] SEG;
  logic [7:0]  AN;
  logic [6:0]  CA;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .SEG   (SEG),
    .AN    (AN),
    .CA    (CA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  function automatic bit visible(input logic [31:0] v, input int d);
`ifdef SEG7_SCAN_LZB_EN
    int lead = 0;
    for (int k = 0; k < 8; k++) if (((v >> (4 * k)) & 32'hF) != 0) lead = k;
    visible = (d <= lead);
`else
    visible = 1'b1;
`endif
  endfunction

  // pos = edges since the frame started (1..64); 64 is cnt=0 of the next frame.
  task automatic expect_at(input logic [32:0] shown, input int pos,
                           output logic [7:0] ea, output logic [6:0] ec);
    int c, d;
    logic [31:0] v;
    c  = pos % SCAN_DIV;
    d  = (pos / SCAN_DIV) % 8;
    v  = shown[31:0];
    ea = 8'hFF;
    ec = 7'h7F;
    if (pos < FRAME && c >= BLANK_CYCLES && shown[32] && visible(v, d)) begin
      ea = ~(8'h01 << d);
      ec = ~glyph(4'((v >> (4 * d)) & 32'hF));
    end
  endtask

  task automatic run_frame(input string name, input logic [32:0] shown,
                           input int chg_at, input logic [32:0] chg_val, input int stop_at);
    logic [7:0] ea;
    logic [6:0] ec;
    for (int j = 0; j < FRAME; j++) begin
      @(posedge CLK);
      #1;
      expect_at(shown, j + 1, ea, ec);
      check($sformatf("%s_an_t%0d", name, j), 64'(AN), 64'(ea));
      check($sformatf("%s_ca_t%0d", name, j), 64'(CA), 64'(ec));
      check($sformatf("%s_onehot_t%0d", name, j), 64'($countones(~AN) <= 1), 64'd1);
      if (j == chg_at) SEG = chg_val;
      if (j == stop_at) return;
    end
  endtask

  initial begin
    Reset = 1'b1;
    SEG   = 33'h1_8765_4321;
    #1;
    check("por_an", 64'(AN), 64'h FF);
    check("por_ca", 64'(CA), 64'h7F);
    #20;
    @(negedge CLK);
    Reset = 1'b0;

    run_frame("f0", 33'h0_0000_0000, -1, 33'h0, -1);
    run_frame("f1", 33'h1_8765_4321, 30, 33'h1_0000_0000, -1);
    run_frame("f2", 33'h1_0000_0000, 20, 33'h1_FFFF_FFFF, -1);
    run_frame("f3", 33'h1_FFFF_FFFF, 10, 33'h0_1234_5678, -1);
    run_frame("f4", 33'h0_1234_5678, -1, 33'h0, -1);
    run_frame("f5", 33'h0_1234_5678, -1, 33'h0, -1);
    run_frame("f6", 33'h0_1234_5678, 40, 33'h1_0000_00A5, -1);
    run_frame("f7", 33'h1_0000_00A5, 40, 33'h1_0000_0000, -1);
    run_frame("f8", 33'h1_0000_0000, 40, 33'h1_8765_4321, -1);

    // Stop at cnt=5 of slot 3 (digit 3 lit), then reset asynchronously.
    run_frame("f9", 33'h1_8765_4321, -1, 33'h0, 28);
    check("pre_rst_an", 64'(AN), 64'hF7);
    Reset = 1'b1;
    #1;
    check("mid_rst_an", 64'(AN), 64'hFF);
    check("mid_rst_ca", 64'(CA), 64'h7F);
    @(negedge CLK);
    Reset = 1'b0;

    run_frame("f10", 33'h0_0000_0000, -1, 33'h0, -1);
    run_frame("f11", 33'h1_8765_4321, -1, 33'h0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Display-side consumer of the memory-mapped segment register. It takes the 33-bit register value, with bit 32 as display enable and bits 31:0 as eight hex nibbles. It time-multiplexes the nibbles onto an 8-digit common-anode seven-segment display and inserts a blanking guard between digits to suppress ghosting. It sits between the segment register output and the board pins.

## Interface
- SCAN_DIV, default 100000: CLK cycles per digit slot; must be ≥ 4.
- BLANK_CYCLES, default 1000: all-anodes-off guard at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < SCAN_DIV.
- CLK  input  1  system clock.
- Reset  input  1  asynchronous, active-high.
- SEG  input  33  register value: [32] enable, [4d+3:4d] digit d, where digit 0 is rightmost.
- AN  output  8  anode selects, active-low; AN[d] drives digit d.
- CA  output  7  cathodes {g,f,e,d,c,b,a}, active-low.

## Operation
- Slot counter `cnt` runs 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index `dig` (3 bits) increments and wraps 7→0.
- Two-state FSM per slot:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE while cnt ≥ BLANK_CYCLES.
- Frame snapshot: `snap` (33 bits) loads SEG on the cycle where cnt==SCAN_DIV-1 and dig==7.
  - The snapshot is used for the whole following frame, so there is no tearing mid-frame.
  - SEG changes at other times have no effect until the next frame boundary.
- BLANK: AN=8'hFF and CA=7'h7F.
- DRIVE with snap[32]==1: AN = ~(8'b1 << dig); CA = ~hex7(snap nibble dig).
- DRIVE with snap[32]==0: AN=8'hFF and CA=7'h7F. Scanning continues regardless.
- hex7 decodes 0–F in standard a–g patterns: 0=7'h3F, 1=7'h06, 8=7'h7F, A=7'h77, F=7'h71 (active-high, before inversion).
- Reset, either at power-up or mid-frame:
  - cnt=0, dig=0, state BLANK, snap=0.
  - AN=8'hFF, CA=7'h7F, taking effect immediately (asynchronous).
  - The first frame after reset is therefore blank. The first visible frame uses the SEG value sampled at the end of that frame.

## Timing
- AN and CA are registered. They are computed from the next-state of cnt, dig and snap, so they update on the same edge as the counters. There are no combinational paths from SEG to the pins.
- Digit d is lit for exactly SCAN_DIV-BLANK_CYCLES cycles per frame. Frame period = 8·SCAN_DIV cycles.
- At any instant at most one AN bit is low.
- Across a slot change, AN is all-ones for exactly BLANK_CYCLES cycles.
- SEG-to-display latency is at most 8·SCAN_DIV + BLANK_CYCLES + 1 cycles.
- A snapshot and a digit wrap on the same edge are both applied. The new snap is used from digit 0's DRIVE phase onward.

## Configuration
- SEG7_SCAN_LZB_EN defined: leading-zero blanking.
  - Digits above the highest nonzero nibble of snap[31:0] are held at AN bit 1 during DRIVE.
  - Digit 0 is always shown.
  - Example: snap[31:0]=32'h0000_00A5 lights digits 0 and 1 only.
  - The leading-digit index is computed once per snapshot and registered with snap.
- SEG7_SCAN_LZB_EN undefined: all eight digits are shown whenever enabled, and no leading-digit logic is compiled.

## Structure
- Shared package `seg7_pkg` holds:
  - the 16-entry active-high pattern constant;
  - DIGITS=8;
  - the blank constants AN_OFF=8'hFF and CA_OFF=7'h7F.
- Sub-module `hex7_decode`: combinational, 4-bit in and 7-bit active-high out, reading the package table.
- The top module holds the counters, FSM, snapshot, optional LZB logic and output registers.

## Test plan
All scenarios use SCAN_DIV=8 and BLANK_CYCLES=2.
- Reset, then SEG=33'h1_8765_4321 held. Frame 0 is blank. In frame 1, slot d has AN=~(1<<d) for cycles 2–7, with CA=~hex7(d+1) (digit 0 shows CA=~7'h06).
- SEG changes from 33'h1_0000_0000 to 33'h1_FFFF_FFFF mid-frame. The current frame keeps showing "0" (CA=~7'h3F). The next frame shows "F" (CA=~7'h71) on all digits.
- SEG=33'h0_1234_5678. AN stays 8'hFF and CA stays 7'h7F through 3 frames, while cnt and dig keep advancing.
- Assert Reset at cnt=5 of slot 3 while digit 3 is lit. AN=8'hFF on the same cycle. After release, dig=0, cnt=0 and snap=0.
- Continuous check over 10 frames: never more than one AN bit low; exactly 2 all-off cycles at every slot boundary.
- With SEG7_SCAN_LZB_EN, SEG=33'h1_0000_00A5: only AN[0] and AN[1] ever go low. With SEG=33'h1_0000_0000, only digit 0 lights, showing "0".
